seg7_scan_decoder: RTL

Reader-side counterpart of the hex-to-7-segment encoder. It samples a multiplexed, active-low 7-segment display bus (segment lines plus digit strobes) and decodes each strobed digit back to a hex nibble. Per-digit stability filtering and legality checks are applied before a value is accepted. It sits on the display bus as a loopback/self-check monitor and presents the decoded word to a host or scoreboard.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_to_hex.sv | 25 ++
 rtl/seg7_scan_decoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes, blank pattern and per-digit FSM states.
package seg7_pkg;

    typedef logic [6:0] seg7_t;
    typedef enum logic [1:0] {IDLE, ACQ, LOCK} dig_state_e;

    localparam seg7_t SEG7_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG7_CODE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of an active-low segment pattern to a hex nibble.
// SEG7_BLANK_EN makes the all-off pattern legal with nibble 0.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  seg7_t      seg,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG7_CODE[i]) begin
                legal  = 1'b1;
                nibble = 4'(i);
            end
        end
`ifdef SEG7_BLANK_EN
        if (seg == SEG7_BLANK) legal = 1'b1;
`endif
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and decodes stable strobed digits to nibbles.
// Define SEG7_BLANK_EN to accept the all-off pattern as blank and expose the blank port.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_n,
    input  logic [DIGITS-1:0]   dig_en_n,
    input  logic                clr,
    output logic [4*DIGITS-1:0] value,
    output logic [DIGITS-1:0]   digit_valid,
    output logic                frame_valid,
    output logic                update,
    output logic                illegal,
    output logic                strobe_err
`ifdef SEG7_BLANK_EN
    ,
    output logic [DIGITS-1:0]   blank
`endif
);

    localparam int              CNT_W   = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    seg7_t             s1_seg;
    logic [DIGITS-1:0] s1_en;
    logic [DIGITS-1:0] act;
    logic              one_hot, multi;
    logic              dec_legal;
    logic [3:0]        dec_nib;

    // Stage 1: reset loads an idle bus so nothing in flight survives rst/clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            s1_seg <= SEG7_BLANK;
            s1_en  <= '1;
        end else begin
            s1_seg <= seg_n;
            s1_en  <= dig_en_n;
        end
    end

    assign act     = ~s1_en;
    assign one_hot = $onehot(act);
    assign multi   = !$onehot0(act);

    seg7_to_hex u_dec (
        .seg    (s1_seg),
        .legal  (dec_legal),
        .nibble (dec_nib)
    );

    dig_state_e        st_q  [DIGITS];
    dig_state_e        st_d  [DIGITS];
    seg7_t             pat_q [DIGITS];
    seg7_t             pat_d [DIGITS];
    logic [CNT_W-1:0]  cnt_q [DIGITS];
    logic [CNT_W-1:0]  cnt_d [DIGITS];
    logic [DIGITS-1:0] same, acc;

    always_ff @(posedge clk) begin
        for (int i = 0; i < DIGITS; i++) begin
            if (rst || clr) begin
                st_q[i]  <= IDLE;
                pat_q[i] <= SEG7_BLANK;
                cnt_q[i] <= '0;
            end else begin
                st_q[i]  <= st_d[i];
                pat_q[i] <= pat_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Only the single strobed digit advances; a locked digit seeing its own pattern never re-accepts.
    always_comb begin
        same = '0;
        acc  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            st_d[i]  = st_q[i];
            pat_d[i] = pat_q[i];
            cnt_d[i] = cnt_q[i];
            if (one_hot && act[i]) begin
                same[i] = (st_q[i] != IDLE) && (s1_seg == pat_q[i]);
                if (same[i]) begin
                    cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
                end else begin
                    pat_d[i] = s1_seg;
                    cnt_d[i] = CNT_W'(1);
                end
                acc[i]  = (cnt_d[i] == CNT_MAX) && !(st_q[i] == LOCK && same[i]);
                st_d[i] = (acc[i] || (st_q[i] == LOCK && same[i])) ? LOCK : ACQ;
            end
        end
    end

    logic [4*DIGITS-1:0] val_d;
    logic [DIGITS-1:0]   vld_d;
    logic                upd_d, ill_d;

    always_comb begin
        val_d = value;
        vld_d = digit_valid;
        upd_d = 1'b0;
        ill_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[i]) begin
                if (dec_legal) begin
                    if (!digit_valid[i] || value[4*i +: 4] != dec_nib) upd_d = 1'b1;
                    val_d[4*i +: 4] = dec_nib;
                    vld_d[i]        = 1'b1;
                end else begin
                    vld_d[i] = 1'b0;
                    ill_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value       <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            update      <= 1'b0;
            illegal     <= 1'b0;
            strobe_err  <= 1'b0;
        end else begin
            value       <= val_d;
            digit_valid <= vld_d;
            frame_valid <= &digit_valid;
            update      <= upd_d;
            illegal     <= ill_d;
            strobe_err  <= multi;
        end
    end

`ifdef SEG7_BLANK_EN
    always_ff @(posedge clk) begin
        for (int i = 0; i < DIGITS; i++) begin
            if (rst || clr) blank[i] <= 1'b0;
            else            blank[i] <= (st_d[i] == LOCK) && (pat_d[i] == SEG7_BLANK);
        end
    end
`endif

endmodule
